// File: rtl/sec_bcd_counter.sv
// BCD seconds counter (00-59): clock prescaler to a 1 s tick, digit advance, minute carry,
// run/pause, clear and validated preset. Optional SEC_DOWN_COUNT_EN adds a `down` input.
module sec_bcd_counter #(
  parameter int unsigned DIV = 50000000,
  parameter int unsigned PW  = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_units,
  input  logic [2:0] load_tens,
`ifdef SEC_DOWN_COUNT_EN
  input  logic       down,
`endif
  output logic [3:0] units,
  output logic [2:0] tens,
  output logic       tick,
  output logic       min_carry,
  output logic       load_err
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          adv_q, adv_d;
  logic [3:0]    units_q, units_d, step_units;
  logic [2:0]    tens_q, tens_d, step_tens;
  logic          tick_q, tick_d, mc_q, mc_d, err_q, err_d;
  logic          step_mc, load_ok, illegal, dn;

  assign load_ok = (load_units <= 4'd9) && (load_tens <= 3'd5);
  assign illegal = (units_q > 4'd9) || (tens_q > 3'd5);
`ifdef SEC_DOWN_COUNT_EN
  assign dn = down;
`else
  assign dn = 1'b0;
`endif

  // Digit value one second later; a corrupted digit pair recovers to 00 silently.
  always_comb begin
    step_units = units_q;
    step_tens  = tens_q;
    step_mc    = 1'b0;
    if (illegal) begin
      step_units = 4'd0;
      step_tens  = 3'd0;
    end else if (!dn) begin
      if (units_q == 4'd9) begin
        step_units = 4'd0;
        if (tens_q == 3'd5) begin
          step_tens = 3'd0;
          step_mc   = 1'b1;
        end else begin
          step_tens = tens_q + 3'd1;
        end
      end else begin
        step_units = units_q + 4'd1;
      end
    end else begin
      if (units_q == 4'd0) begin
        step_units = 4'd9;
        if (tens_q == 3'd0) begin
          step_tens = 3'd5;
          step_mc   = 1'b1;
        end else begin
          step_tens = tens_q - 3'd1;
        end
      end else begin
        step_units = units_q - 4'd1;
      end
    end
  end

  // clear > valid load > advance; a rejected load leaves normal counting untouched.
  always_comb begin
    presc_d = presc_q;
    adv_d   = adv_q;
    units_d = units_q;
    tens_d  = tens_q;
    tick_d  = 1'b0;
    mc_d    = 1'b0;
    err_d   = 1'b0;
    if (clear) begin
      presc_d = '0;
      adv_d   = 1'b0;
      units_d = 4'd0;
      tens_d  = 3'd0;
    end else if (load && load_ok) begin
      presc_d = '0;
      adv_d   = 1'b0;
      units_d = load_units;
      tens_d  = load_tens;
    end else begin
      err_d = load;
      if (run) begin
        if (adv_q) begin
          units_d = step_units;
          tens_d  = step_tens;
          tick_d  = 1'b1;
          mc_d    = step_mc;
          adv_d   = 1'b0;
        end
        if (presc_q == LAST) begin
          presc_d = '0;
          adv_d   = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      adv_q   <= 1'b0;
      units_q <= 4'd0;
      tens_q  <= 3'd0;
      tick_q  <= 1'b0;
      mc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      adv_q   <= adv_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      tick_q  <= tick_d;
      mc_q    <= mc_d;
      err_q   <= err_d;
    end
  end

  assign units     = units_q;
  assign tens      = tens_q;
  assign tick      = tick_q;
  assign min_carry = mc_q;
  assign load_err  = err_q;

endmodule
